// File: rtl/sram_arb_pkg.sv
// Shared types for the two-requester SRAM port arbiter.
package sram_arb_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: ready never depends on the requester's own valid.
module rr_arbiter_2
  import sram_arb_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    enable,
  input  logic    valid0,
  input  logic    valid1,
  output logic    ready0,
  output logic    ready1,
  output logic    grant_any,
  output req_id_t grant_id
);

  req_id_t rr_ptr;
  logic    grant0;
  logic    grant1;

  always_comb begin
    ready0    = enable && (!valid1 || rr_ptr == req_id_t'(0));
    ready1    = enable && (!valid0 || rr_ptr == req_id_t'(1));
    grant0    = valid0 && ready0;
    grant1    = valid1 && ready1;
    grant_any = grant0 || grant1;
    grant_id  = grant1 ? req_id_t'(1) : req_id_t'(0);
  end

  // Pointer moves only under contention, to the requester that lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (enable && valid0 && valid1) begin
      rr_ptr <= grant1 ? req_id_t'(0) : req_id_t'(1);
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port RW SRAM between two requesters, with an optional
// post-reset zeroing sweep and fixed 1-cycle read responses.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MASK_W        = 4,
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_wmode,
  input  logic [MASK_W-1:0] req0_wmask,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_wmode,
  input  logic [MASK_W-1:0] req1_wmask,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam state_e RESET_ST = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic              resp_pending;
  req_id_t           resp_id;

  logic              arb_enable;
  logic              arb_ready0;
  logic              arb_ready1;
  logic              grant_any;
  req_id_t           grant_id;
  logic              gnt_wmode;

  assign arb_enable = !reset && (state == ST_RUN);

  rr_arbiter_2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .enable    (arb_enable),
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .ready0    (arb_ready0),
    .ready1    (arb_ready1),
    .grant_any (grant_any),
    .grant_id  (grant_id)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RESET_ST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT: if (init_cnt == LAST_ADDR) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + ADDR_W'(1);
    end
  end

  always_comb begin
    sram_en     = 1'b0;
    sram_wmode  = 1'b0;
    sram_wmask  = '0;
    sram_wdata  = '0;
    sram_addr   = '0;
    gnt_wmode   = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    init_done   = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    if (!reset) begin
      unique case (state)
        ST_INIT: begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_wmask = '1;
          sram_addr  = init_cnt;
        end
        ST_RUN: begin
          init_done  = 1'b1;
          req0_ready = arb_ready0;
          req1_ready = arb_ready1;
          if (grant_any) begin
            sram_en = 1'b1;
            if (grant_id == req_id_t'(0)) begin
              sram_addr  = req0_addr;
              sram_wmode = req0_wmode;
              sram_wmask = req0_wmask;
              sram_wdata = req0_wdata;
            end else begin
              sram_addr  = req1_addr;
              sram_wmode = req1_wmode;
              sram_wmask = req1_wmask;
              sram_wdata = req1_wdata;
            end
            gnt_wmode = sram_wmode;
          end
        end
        default: ;
      endcase
      resp0_valid = resp_pending && (resp_id == req_id_t'(0));
      resp1_valid = resp_pending && (resp_id == req_id_t'(1));
    end
  end

  assign resp0_rdata = sram_rdata;
  assign resp1_rdata = sram_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_pending <= 1'b0;
      resp_id      <= '0;
    end else begin
      resp_pending <= grant_any && !gnt_wmode;
      resp_id      <= grant_id;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 16-entry RW SRAM.
module tb_sram_port_arbiter;

  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 32;
  localparam int unsigned MW  = 4;
  localparam int unsigned DEP = 16;

  logic          clock;
  logic          reset;
  logic          req0_valid, req0_ready, req0_wmode;
  logic [AW-1:0] req0_addr;
  logic [MW-1:0] req0_wmask;
  logic [DW-1:0] req0_wdata;
  logic          resp0_valid;
  logic [DW-1:0] resp0_rdata;
  logic          req1_valid, req1_ready, req1_wmode;
  logic [AW-1:0] req1_addr;
  logic [MW-1:0] req1_wmask;
  logic [DW-1:0] req1_wdata;
  logic          resp1_valid;
  logic [DW-1:0] resp1_rdata;
  logic [AW-1:0] sram_addr;
  logic          sram_en, sram_wmode;
  logic [MW-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          init_done;

  int checks = 0;
  int errors = 0;

  sram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .DEPTH(DEP), .INIT_ON_RESET(1)
  ) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wmode(req0_wmode), .req0_wmask(req0_wmask), .req0_wdata(req0_wdata),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wmode(req1_wmode), .req1_wmask(req1_wmask), .req1_wdata(req1_wdata),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .init_done(init_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RW0 macro: masked write, registered read data.
  logic [DW-1:0] mem [DEP];
  logic [DW-1:0] rq;
  initial begin
    for (int i = 0; i < int'(DEP); i++) mem[i] = 32'hBAD0_0000 | i;
    rq = '0;
  end
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < int'(MW); l++)
          if (sram_wmask[l]) mem[sram_addr[3:0]][l*8 +: 8] <= sram_wdata[l*8 +: 8];
      end else begin
        rq <= mem[sram_addr[3:0]];
      end
    end
  end
  assign sram_rdata = rq;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0; req0_addr = '0; req0_wmode = 1'b0; req0_wmask = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_wmode = 1'b0; req1_wmask = '0; req1_wdata = '0;
  endtask

  task automatic drv0(input logic [AW-1:0] a, input logic wm, input logic [MW-1:0] m,
                      input logic [DW-1:0] d);
    req0_valid = 1'b1; req0_addr = a; req0_wmode = wm; req0_wmask = m; req0_wdata = d;
  endtask

  task automatic drv1(input logic [AW-1:0] a, input logic wm, input logic [MW-1:0] m,
                      input logic [DW-1:0] d);
    req1_valid = 1'b1; req1_addr = a; req1_wmode = wm; req1_wmask = m; req1_wdata = d;
  endtask

  function automatic logic [DW-1:0] expv(input int a);
    case (a)
      3:       return 32'h3333_3333;
      5:       return 32'h5555_5555;
      7:       return 32'hAA22_CC44;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    step(); step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_en", sram_en, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_done", init_done, 0);
    chk("rst_resp0", resp0_valid, 0);
    idle();

    // Sweep interrupted by reset at address 6
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("mid_addr", sram_addr, k);
      step();
    end
    #1;
    chk("mid_addr6", sram_addr, 6);
    reset = 1'b1;
    #1;
    chk("mid_rst_en", sram_en, 0);
    step();
    reset = 1'b0;

    // Full sweep with a waiting requester that must not be accepted
    drv0(10'd2, 1'b0, 4'h0, 32'h0);
    for (int k = 0; k < int'(DEP); k++) begin
      #1;
      chk("swp_en", sram_en, 1);
      chk("swp_wmode", sram_wmode, 1);
      chk("swp_wmask", sram_wmask, 4'hF);
      chk("swp_wdata", sram_wdata, 0);
      chk("swp_addr", sram_addr, k);
      chk("swp_rdy0", req0_ready, 0);
      chk("swp_done", init_done, 0);
      step();
    end
    idle();
    #1;
    chk("done_rise", init_done, 1);
    chk("run_idle_en", sram_en, 0);
    step();

    // Seed addresses 3 and 5
    drv0(10'd3, 1'b1, 4'hF, 32'h3333_3333);
    #1;
    chk("w3_rdy", req0_ready, 1);
    chk("w3_en", sram_en, 1);
    step();
    idle();
    drv1(10'd5, 1'b1, 4'hF, 32'h5555_5555);
    #1;
    chk("w5_rdy", req1_ready, 1);
    chk("w3_noresp", resp0_valid, 0);
    step();
    idle();

    // Masked write
    drv0(10'd7, 1'b1, 4'hF, 32'hAABB_CCDD);
    step();
    drv0(10'd7, 1'b1, 4'h5, 32'h1122_3344);
    #1;
    chk("mw_wmask", sram_wmask, 4'h5);
    step();
    drv0(10'd7, 1'b0, 4'h0, 32'h0);
    #1;
    chk("mr_addr", sram_addr, 7);
    chk("mr_wmode", sram_wmode, 0);
    step();
    idle();
    #1;
    chk("mr_v0", resp0_valid, 1);
    chk("mr_v1", resp1_valid, 0);
    chk("mr_data", resp0_rdata, 32'hAA22_CC44);
    step();

    // Contention: grants 0,1,0,1
    drv0(10'd3, 1'b0, 4'h0, 32'h0);
    drv1(10'd5, 1'b0, 4'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("ct_rdy0", req0_ready, (c % 2) == 0);
      chk("ct_rdy1", req1_ready, (c % 2) == 1);
      chk("ct_addr", sram_addr, ((c % 2) == 1) ? 5 : 3);
      if (c > 0) begin
        chk("ct_v0", resp0_valid, ((c - 1) % 2) == 0);
        chk("ct_v1", resp1_valid, ((c - 1) % 2) == 1);
        chk("ct_data", resp0_rdata, (((c - 1) % 2) == 1) ? 32'h5555_5555 : 32'h3333_3333);
      end else begin
        chk("ct_v0_first", resp0_valid, 0);
      end
      step();
    end
    idle();
    #1;
    chk("ct_last_v1", resp1_valid, 1);
    chk("ct_last_v0", resp0_valid, 0);
    chk("ct_last_data", resp1_rdata, 32'h5555_5555);
    step();

    // Write then read on requester 1
    drv1(10'd9, 1'b1, 4'hF, 32'hDEAD_BEEF);
    #1;
    chk("wr9_rdy", req1_ready, 1);
    step();
    drv1(10'd9, 1'b0, 4'h0, 32'h0);
    #1;
    chk("wr9_noresp", resp1_valid, 0);
    step();
    idle();
    #1;
    chk("rd9_v1", resp1_valid, 1);
    chk("rd9_data", resp1_rdata, 32'hDEAD_BEEF);
    step();

    // Lone requester streaming
    for (int i = 0; i < 8; i++) begin
      drv0(AW'(i), 1'b0, 4'h0, 32'h0);
      #1;
      chk("st_rdy0", req0_ready, 1);
      if (i > 0) begin
        chk("st_v0", resp0_valid, 1);
        chk("st_data", resp0_rdata, expv(i - 1));
      end
      step();
    end
    idle();
    #1;
    chk("st_last_v0", resp0_valid, 1);
    chk("st_last_data", resp0_rdata, expv(7));
    step();

    // Reset with a read pending
    drv0(10'd3, 1'b0, 4'h0, 32'h0);
    step();
    idle();
    reset = 1'b1;
    #1;
    chk("rp_v0", resp0_valid, 0);
    chk("rp_v1", resp1_valid, 0);
    chk("rp_en", sram_en, 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < int'(DEP); k++) begin
      #1;
      if (k == 0) chk("rp_v0_after", resp0_valid, 0);
      chk("rs_addr", sram_addr, k);
      step();
    end
    #1;
    chk("rs_done", init_done, 1);
    for (int i = 0; i < int'(DEP); i++) begin
      drv0(AW'(i), 1'b0, 4'h0, 32'h0);
      #1;
      if (i > 0) begin
        chk("zr_v0", resp0_valid, 1);
        chk("zr_data", resp0_rdata, 0);
      end
      step();
    end
    idle();
    #1;
    chk("zr_last_v0", resp0_valid, 1);
    chk("zr_last_data", resp0_rdata, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port behavioural RW SRAM macro (RW0-style port, 1-cycle registered-address read) between two requesters, e.g. a cache refill engine and a core-side access path.
- Provides a valid/ready request channel and a fixed-latency response channel per requester, with round-robin arbitration.
- Runs an optional post-reset zero-initialisation sweep so simulation and FPGA start from known contents.
- Sits between the cache control logic and the *_ext SRAM instance; the SRAM's RW0_* ports connect directly to the sram_* ports.

Parameters:
- ADDR_W, 10, SRAM address width.
- DATA_W, 32, SRAM data width.
- MASK_W, 4, write-mask width; each bit covers DATA_W/MASK_W bits.
- DEPTH, 1024, number of SRAM entries; must be ≤ 2^ADDR_W.
- INIT_ON_RESET, 1, when 1, zero all entries after reset before accepting requests.

Ports:
- clock  in  1  single clock for the block and the SRAM.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 request valid.
- req0_ready  out  1  requester 0 request accepted this cycle when valid and ready are both high.
- req0_addr  in  ADDR_W  request address.
- req0_wmode  in  1  1 = write, 0 = read.
- req0_wmask  in  MASK_W  write byte-lane mask; ignored on reads.
- req0_wdata  in  DATA_W  write data.
- resp0_valid  out  1  read data valid for requester 0.
- resp0_rdata  out  DATA_W  read data for requester 0.
- req1_*, resp1_*  same widths and meanings as above, for requester 1.
- sram_addr  out  ADDR_W  to RW0_addr.
- sram_en  out  1  to RW0_en.
- sram_wmode  out  1  to RW0_wmode.
- sram_wmask  out  MASK_W  to RW0_wmask.
- sram_wdata  out  DATA_W  to RW0_wdata.
- sram_rdata  in  DATA_W  from RW0_rdata.
- init_done  out  1  high once the block is in RUN.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - While reset is high: state is set to INIT (or RUN if INIT_ON_RESET=0), init counter = 0, rr_ptr = 0, resp_pending = 0.
  - Combinational outputs are forced while reset is high: sram_en=0, req*_ready=0, resp*_valid=0, init_done=0.
- FSM states: INIT and RUN.
  - INIT, every cycle: sram_en=1, wmode=1, wmask=all ones, wdata=0, addr=init_cnt. init_cnt increments by 1.
  - Leaving INIT: the cycle that writes address DEPTH-1 transitions to RUN. There is no wrap-around; init_cnt is never used in RUN.
  - All req*_ready are 0 in INIT.
  - RUN: init_done=1, and the state is held until reset.
- Arbitration (RUN only):
  - ready0 = !req1_valid || rr_ptr==0.
  - ready1 = !req0_valid || rr_ptr==1.
  - Ready never depends on the requester's own valid.
  - At most one grant per cycle.
  - rr_ptr updates only when both requesters are valid in the same cycle: it points at the requester that was not granted. A lone requester gets back-to-back grants every cycle with no bubble.
- SRAM drive: combinational from the granted request, so an accepted request reaches the SRAM in the same cycle. With no grant, sram_en=0 and all other sram_* outputs are 0.
- Read response:
  - An accepted read (wmode=0) sets resp_pending=1 and resp_id=granted requester.
  - The next cycle, respN_valid=1 for exactly one cycle with respN_rdata=sram_rdata.
  - Latency is exactly 1 cycle after acceptance, with no backpressure; the requester must take it.
  - resp*_rdata is driven with sram_rdata at all times; only valid qualifies it.
- Writes: accepted writes produce no response. Only lanes whose wmask bit is 1 change.
- Write then read: a read of the same address accepted in the cycle after a write returns the newly written data.
- Back-to-back reads: a read accepted in the same cycle as a pending response is legal, giving one response per cycle.
- Reset mid-operation: any pending response is dropped (no valid emitted), and the init sweep restarts at address 0.

Decomposition:
- Package sram_arb_pkg holds:
  - the state enum (ST_INIT, ST_RUN);
  - the requester-id type (1 bit);
  - the constant NUM_REQ=2.
- Sub-module rr_arbiter_2 holds the round-robin pointer, grant and ready logic.
- The top level holds the FSM, init counter, SRAM mux and response tracking.

Test Plan:
1. INIT sweep (DEPTH=16): release reset → sram_en=1 with wmode=1 and wdata=0 for addr 0..15 on 16 consecutive cycles; init_done rises in cycle 17; no ready during the sweep.
2. Contention: both requesters hold reads of addr 3 and addr 5 for 4 cycles, rr_ptr=0 → grants alternate 0,1,0,1; each resp arrives 1 cycle after its grant with the correct requester id.
3. Masked write: write 0xAABBCCDD with mask 4'b1111 to addr 7, then 0x11223344 with mask 4'b0101, then read addr 7 → resp_rdata = 0xAA22CC44.
4. Write then read: requester 1 writes 0xDEADBEEF to addr 9, then reads addr 9 in the next cycle → resp1_valid two cycles after the write grant with 0xDEADBEEF.
5. Reset mid-INIT at addr 6 and reset with a read pending → no resp*_valid pulse; the sweep restarts at addr 0 and all 16 entries read back as 0.
6. Lone requester streaming: req0 valid for 8 reads with req1 idle → ready0 high every cycle and 8 consecutive resp0_valid pulses.
